universal_shift_register: RTL
=============================

Name: universal_shift_register

Overview:
Parametrised successor to the team's 4-bit universal shift register. Adds rotate and arithmetic modes, a registered serial-out, and a sequenced multi-step shift engine. The engine uses a Start/Busy/Done handshake and a shift count. It is a general datapath building block for serialisers, shift-add multipliers and lab datapaths, on a single clock domain.

Parameters:
WIDTH, 8, register width in bits (>= 2)
AMT_WIDTH, 4, width of the Amount port; maximum sequenced step count is 2^AMT_WIDTH-1

Ports:
Clock  in  1  rising-edge clock
ResetN  in  1  asynchronous active-low reset
I  in  WIDTH  parallel load data
Mode  in  3  operation select
W  in  1  serial fill bit for logical shifts
Start  in  1  request a sequenced shift of Amount steps
Amount  in  AMT_WIDTH  step count for a sequenced shift
Q  out  WIDTH  register contents
SerialOut  out  1  last bit shifted or rotated out (registered)
Busy  out  1  high while a sequenced shift is running
Done  out  1  one-cycle pulse when a sequenced shift completes

Behaviour:
- Clocking: one clock (Clock). Reset is asynchronous and active-low (ResetN).
- Reset: ResetN=0 immediately forces Q=0, SerialOut=0, Busy=0, Done=0, FSM=IDLE, step counter=0. This applies at any time, including mid-sequence. The aborted sequence never produces Done.
- Mode encoding, applied as one step:
  - 0: hold.
  - 1: shift left, LSB<=W.
  - 2: shift right, MSB<=W.
  - 3: load Q<=I.
  - 4: rotate left.
  - 5: rotate right.
  - 6: arithmetic shift right, MSB replicated.
  - 7: reserved, behaves as hold.
- SerialOut per step:
  - Modes 1 and 4 capture the old Q[WIDTH-1].
  - Modes 2, 5 and 6 capture the old Q[0].
  - Modes 0, 3 and 7 leave SerialOut unchanged.
- FSM states: IDLE and SHIFT.
- IDLE, Start=0: Mode is executed as a single step on every rising edge (immediate mode).
- IDLE, Start=1, Mode in {1,2,4,5,6}:
  - That edge latches Mode, W and Amount into internal registers. Q is unchanged on that edge.
  - If Amount>0: go to SHIFT and set Busy=1.
  - If Amount=0: stay IDLE, Busy stays 0, and Done=1 for the next cycle.
- IDLE, Start=1, Mode in {0,3,7}: Start is ignored and Mode is executed as an immediate op.
- SHIFT state:
  - Each edge performs one step of the latched mode with the latched W, and decrements the counter.
  - The edge that performs the final step sets FSM=IDLE, Busy=0 and Done=1 for exactly one cycle.
  - Mode, W, I, Start and Amount are ignored while Busy=1.
- Latency: Start with Amount=N>0 sampled at edge k. Steps occur at edges k+1..k+N. Busy is high between edge k and edge k+N. Done is high between edge k+N and edge k+N+1. Q holds the final result when Done is high.
- Back-to-back sequences: a new Start is accepted in the cycle Done is high, because the FSM is IDLE then.
- Step counts of Amount >= WIDTH are legal:
  - Logical shifts fill completely with W.
  - ASR fills with the sign bit.
  - Rotates wrap modulo WIDTH.
- Done is a registered pulse and is never high for two consecutive cycles from the same sequence.

Test Plan:
- WIDTH=8. Reset, then Mode=3 with I=8'hB4 -> Q=8'hB4 after one edge. Mode=0 for 3 edges -> Q stays 8'hB4, SerialOut=0, Busy=0, Done=0.
- From Q=8'hB4, Mode=4 for 2 edges -> Q=8'h69 with SerialOut=1, then Q=8'hD2 with SerialOut=0. Mode=5 for 1 edge -> Q=8'h69, SerialOut=0.
- Load 8'h81, Mode=6 for 2 edges -> Q=8'hC0 with SerialOut=1, then Q=8'hE0 with SerialOut=0. Load 8'h81, Mode=2 with W=0 for 1 edge -> Q=8'h40.
- Load 8'h01, then Start=1, Mode=1, W=0, Amount=5; during Busy drive Mode=3, I=8'hFF -> Busy high for exactly 5 cycles, then Done high for 1 cycle with Q=8'h20. Q never equals 8'hFF.
- From IDLE, Start=1, Mode=2, Amount=0 -> Busy never asserts, Done high for one cycle after the Start edge, Q unchanged. Immediately Start=1, Mode=5, Amount=8 on Q=8'h3C -> Q=8'h3C when Done.
- Sequence with Amount=6 on Q=8'hFF, Mode=1, W=0; drop ResetN asynchronously after 2 steps (between edges) -> Q=0 and Busy=0 with no clock edge. After ResetN releases, the FSM is IDLE, no Done pulse occurs, and an immediate Mode=3 load works.

Source files
------------

// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : universal_shift_register
//  Description : Parametrised universal shift register with hold, logical
//                shift, load, rotate and arithmetic modes, a registered
//                serial-out, and a sequenced multi-step shift engine driven
//                by a Start/Busy/Done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_register #(
  parameter int WIDTH     = 8,
  parameter int AMT_WIDTH = 4
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic [WIDTH-1:0]     I,
  input  logic [2:0]           Mode,
  input  logic                 W,
  input  logic                 Start,
  input  logic [AMT_WIDTH-1:0] Amount,
  output logic [WIDTH-1:0]     Q,
  output logic                 SerialOut,
  output logic                 Busy,
  output logic                 Done
);

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHL  = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_LOAD = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;

  localparam logic [AMT_WIDTH-1:0] CNT_ONE = AMT_WIDTH'(1);
  localparam logic [AMT_WIDTH-1:0] CNT_ZERO = '0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     q_reg, q_next;
  logic                 so_reg, so_next;
  logic                 done_reg, done_next;
  logic [AMT_WIDTH-1:0] cnt, cnt_next;
  logic [2:0]           lat_mode, lat_mode_next;
  logic                 lat_w, lat_w_next;

  logic [2:0]           step_mode;
  logic                 step_w;
  logic [WIDTH-1:0]     step_q;
  logic                 step_so;
  logic                 mode_is_shift;

  // While sequencing, the latched operation drives the step datapath.
  assign step_mode = (state == SHIFT) ? lat_mode : Mode;
  assign step_w    = (state == SHIFT) ? lat_w    : W;

  // Only the modes that move bits may start a sequence.
  assign mode_is_shift = (Mode == MODE_SHL) || (Mode == MODE_SHR) ||
                         (Mode == MODE_ROL) || (Mode == MODE_ROR) ||
                         (Mode == MODE_ASR);

  // One step of the selected operation, with the bit it pushes out.
  always_comb begin
    step_q  = q_reg;
    step_so = so_reg;
    case (step_mode)
      MODE_SHL: begin
        step_q  = {q_reg[WIDTH-2:0], step_w};
        step_so = q_reg[WIDTH-1];
      end
      MODE_SHR: begin
        step_q  = {step_w, q_reg[WIDTH-1:1]};
        step_so = q_reg[0];
      end
      MODE_LOAD: step_q = I;
      MODE_ROL: begin
        step_q  = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        step_so = q_reg[WIDTH-1];
      end
      MODE_ROR: begin
        step_q  = {q_reg[0], q_reg[WIDTH-1:1]};
        step_so = q_reg[0];
      end
      MODE_ASR: begin
        step_q  = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
        step_so = q_reg[0];
      end
      default: begin
        step_q  = q_reg;
        step_so = so_reg;
      end
    endcase
  end

  // Next-state and datapath update selection for the sequencing FSM.
  always_comb begin
    state_next    = state;
    q_next        = q_reg;
    so_next       = so_reg;
    done_next     = 1'b0;
    cnt_next      = cnt;
    lat_mode_next = lat_mode;
    lat_w_next    = lat_w;
    case (state)
      IDLE: begin
        if (Start && mode_is_shift) begin
          // Accepting a sequence leaves Q untouched on this edge.
          lat_mode_next = Mode;
          lat_w_next    = W;
          cnt_next      = Amount;
          if (Amount != CNT_ZERO) begin
            state_next = SHIFT;
          end else begin
            done_next = 1'b1;
          end
        end else begin
          q_next  = step_q;
          so_next = step_so;
        end
      end
      SHIFT: begin
        q_next   = step_q;
        so_next  = step_so;
        cnt_next = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any sequence without Done.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      q_reg    <= '0;
      so_reg   <= 1'b0;
      done_reg <= 1'b0;
      cnt      <= '0;
      lat_mode <= MODE_HOLD;
      lat_w    <= 1'b0;
    end else begin
      state    <= state_next;
      q_reg    <= q_next;
      so_reg   <= so_next;
      done_reg <= done_next;
      cnt      <= cnt_next;
      lat_mode <= lat_mode_next;
      lat_w    <= lat_w_next;
    end
  end

  assign Q         = q_reg;
  assign SerialOut = so_reg;
  assign Busy      = (state == SHIFT);
  assign Done      = done_reg;

endmodule
`default_nettype wire
